// File: rtl/lattuino_spm_pkg.sv
// Shared definitions for the Lattuino SPM page writer: command codes and FSM states.
package lattuino_spm_pkg;

  localparam logic [1:0] CMD_FILL  = 2'b00;
  localparam logic [1:0] CMD_ERASE = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_PRIME,
    S_WRITE,
    S_DONE
  } spm_state_t;

endpackage

// File: rtl/spm_page_buf.sv
// One-page word buffer: single write port, registered read port (BRAM/LUTRAM friendly).
module spm_page_buf #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned PAGE_W    = 6
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [PAGE_W-1:0]    wr_addr_i,
  input  logic [WORD_SIZE-1:0] wr_data_i,
  input  logic [PAGE_W-1:0]    rd_addr_i,
  output logic [WORD_SIZE-1:0] rd_data_o
);

  logic [WORD_SIZE-1:0] mem_q [2**PAGE_W];
  logic [WORD_SIZE-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/spm_page_writer.sv
// SPM controller: collects fills into a page buffer, then erases/programs a whole page.
// Optional boot-region write protection is enabled with `define BOOT_LOCK_EN.
module spm_page_writer
  import lattuino_spm_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned PAGE_W     = 6,
  parameter int unsigned BOOT_START = 1720
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 spm_i,
  input  logic [1:0]           cmd_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 denied_o,
  output logic                 pm_sel_o,
  output logic [ADDR_W-1:0]    pm_addr_o,
  output logic [WORD_SIZE-1:0] pm_data_o,
  output logic                 pm_we_o
);

  localparam int unsigned DEPTH = 2**PAGE_W;
  localparam int unsigned PG_W  = ADDR_W - PAGE_W;

  spm_state_t          state_q, state_d;
  logic [PAGE_W-1:0]   cnt_q, cnt_d;
  logic [PG_W-1:0]     page_q, page_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic                buf_we;
  logic [PAGE_W-1:0]   buf_rd_addr;
  logic [WORD_SIZE-1:0] buf_rd_data;
  logic                last_beat;
  logic                locked;

  assign last_beat = (cnt_q == '1);

`ifdef BOOT_LOCK_EN
  logic denied_q, denied_d;

  // A page is protected if its last word reaches into the bootloader region.
  assign locked = ({addr_i[ADDR_W-1:PAGE_W], {PAGE_W{1'b1}}} >= ADDR_W'(BOOT_START));

  always_comb begin
    denied_d = denied_q;
    if (state_q == S_IDLE && spm_i && (cmd_i == CMD_ERASE || cmd_i == CMD_WRITE)) begin
      denied_d = locked;
    end else if (state_q == S_DONE) begin
      denied_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) denied_q <= 1'b0;
    else         denied_q <= denied_d;
  end

  assign denied_o = denied_q && (state_q == S_DONE);
`else
  assign locked   = 1'b0;
  assign denied_o = 1'b0;
`endif

  spm_page_buf #(
    .WORD_SIZE(WORD_SIZE),
    .PAGE_W   (PAGE_W)
  ) u_buf (
    .clk_i    (clk_i),
    .we_i     (buf_we),
    .wr_addr_i(addr_i[PAGE_W-1:0]),
    .wr_data_i(data_i),
    .rd_addr_i(buf_rd_addr),
    .rd_data_o(buf_rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      page_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    page_d      = page_q;
    valid_d     = valid_q;
    buf_we      = 1'b0;
    buf_rd_addr = cnt_q;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    pm_sel_o    = 1'b0;
    pm_we_o     = 1'b0;
    pm_addr_o   = '0;
    pm_data_o   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (spm_i) begin
          unique case (cmd_i)
            CMD_FILL: begin
              buf_we = 1'b1;
              valid_d[addr_i[PAGE_W-1:0]] = 1'b1;
            end
            CMD_ERASE: begin
              page_d  = addr_i[ADDR_W-1:PAGE_W];
              cnt_d   = '0;
              state_d = locked ? S_DONE : S_ERASE;
            end
            CMD_WRITE: begin
              page_d  = addr_i[ADDR_W-1:PAGE_W];
              cnt_d   = '0;
              state_d = locked ? S_DONE : S_PRIME;
              if (locked) valid_d = '0;
            end
            default: ;
          endcase
        end
      end

      S_ERASE: begin
        busy_o    = 1'b1;
        pm_sel_o  = 1'b1;
        pm_we_o   = 1'b1;
        pm_addr_o = {page_q, cnt_q};
        pm_data_o = '1;
        cnt_d     = cnt_q + 1'b1;
        if (last_beat) state_d = S_DONE;
      end

      S_PRIME: begin
        busy_o    = 1'b1;
        pm_sel_o  = 1'b1;
        pm_addr_o = {page_q, cnt_q};
        state_d   = S_WRITE;
      end

      S_WRITE: begin
        busy_o      = 1'b1;
        pm_sel_o    = 1'b1;
        pm_we_o     = 1'b1;
        pm_addr_o   = {page_q, cnt_q};
        pm_data_o   = valid_q[cnt_q] ? buf_rd_data : '1;
        // Read one word ahead so the registered buffer output lines up with cnt.
        buf_rd_addr = cnt_q + 1'b1;
        cnt_d       = cnt_q + 1'b1;
        if (last_beat) begin
          valid_d = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        busy_o    = 1'b1;
        pm_sel_o  = 1'b1;
        done_o    = 1'b1;
        pm_addr_o = {page_q, cnt_q};
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
